video_sync_decoder: RTL and testbench

- Monitor-side receiver for the Apple-1 terminal video timing: consumes the dot-rate sync, blanking and pixel stream and recovers the raster.
- Measures line length and lines per frame, and decides horizontal lock.
- Outputs per-dot pixel coordinates plus a valid flag, for on-chip frame capture and self-checking of the terminal timing chain.

---
 rtl/video_sync_decoder_if.sv | 39 +++
 rtl/video_sync_decoder.sv | 198 +++++++++++++++++++
 tb/tb_video_sync_decoder.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_sync_decoder_if.sv
// video_sync_decoder_if
// Bundles the dot-rate video input stream and the recovered raster outputs
// of the Apple-1 video sync decoder.
//   dot_en      : one-clk strobe per dot, qualifies every input sample
//   h_sync_n    : horizontal sync, active low
//   vbl         : vertical blank, active high
//   video       : pixel data
//   locked      : horizontal lock achieved
//   px_valid    : current dot is active and locked
//   px_x / px_y : active column / active line of the current dot
//   px_data     : registered video sample (0 outside the active window)
//   frame_start : one-clk pulse on the vbl fall
//   line_len    : last measured line length in dots
//   frame_lines : h_sync_n falls between the last two vbl falls
// The master side is the video source, the slave side is the decoder.
interface video_sync_decoder_if;
  logic       dot_en;
  logic       h_sync_n;
  logic       vbl;
  logic       video;
  logic       locked;
  logic       px_valid;
  logic [8:0] px_x;
  logic [7:0] px_y;
  logic       px_data;
  logic       frame_start;
  logic [9:0] line_len;
  logic [8:0] frame_lines;

  modport master (
    output dot_en, h_sync_n, vbl, video,
    input  locked, px_valid, px_x, px_y, px_data, frame_start, line_len, frame_lines
  );

  modport slave (
    input  dot_en, h_sync_n, vbl, video,
    output locked, px_valid, px_x, px_y, px_data, frame_start, line_len, frame_lines
  );
endinterface

// File: rtl/video_sync_decoder.sv
// video_sync_decoder
// Monitor-side receiver for the Apple-1 terminal video timing. It measures
// the line length between h_sync_n falls, decides horizontal lock, counts
// lines per frame between vbl falls, and emits per-dot raster coordinates.
// Ports:
//   clk : system clock (twice the dot rate)
//   mr  : master reset, synchronous, active high
//   bus : video_sync_decoder_if.slave (dot stream in, raster info out)
// All inputs are sampled only on dot_en cycles; outputs change one clk
// after the dot_en sample. frame_start is the only output that also changes
// on non-dot cycles (it is cleared there).
module video_sync_decoder #(
  parameter int unsigned H_NOMINAL  = 455,
  parameter int unsigned H_TOL      = 2,
  parameter int unsigned H_TIMEOUT  = 1000,
  parameter int unsigned LOCK_LINES = 4,
  parameter int unsigned MISS_MAX   = 3,
  parameter int unsigned H_START    = 80,
  parameter int unsigned ACTIVE_W   = 280,
  parameter int unsigned ACTIVE_H   = 192
) (
  input logic                 clk,
  input logic                 mr,
  video_sync_decoder_if.slave bus
);

  localparam int GW = $clog2(LOCK_LINES + 1);
  localparam int MW = $clog2(MISS_MAX + 1);

  // Line length is judged in 11 bits so that h_cnt+1 = 1024 cannot wrap
  // into an apparently short line.
  localparam logic [10:0] NOM  = 11'(H_NOMINAL);
  localparam logic [10:0] TOL  = 11'(H_TOL);
  localparam logic [9:0]  TMO  = 10'(H_TIMEOUT);
  localparam logic [9:0]  X_LO = 10'(H_START);
  localparam logic [9:0]  X_HI = 10'(H_START + ACTIVE_W);
  localparam logic [8:0]  Y_HI = 9'(ACTIVE_H);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [GW-1:0]  good_q, good_d;
  logic [MW-1:0]  miss_q, miss_d;
  logic           prev_hs, prev_vbl;
  logic [9:0]     h_cnt, h_next;
  logic [8:0]     y_cnt, y_next;
  logic [10:0]    len_new, len_diff;
  logic           hs_fall, vb_fall, line_good, timeout, pix_ok;
  logic [8:0]     x_off;

  logic [9:0]     line_len_q;
  logic [8:0]     frame_lines_q;
  logic           px_valid_q, px_data_q, frame_start_q;
  logic [8:0]     px_x_q;
  logic [7:0]     px_y_q;

  // Edges are the previous dot sample against the one arriving now.
  assign hs_fall = bus.dot_en & prev_hs & ~bus.h_sync_n;
  assign vb_fall = bus.dot_en & prev_vbl & ~bus.vbl;

  assign len_new   = {1'b0, h_cnt} + 11'd1;
  assign len_diff  = (len_new >= NOM) ? (len_new - NOM) : (NOM - len_new);
  assign line_good = (len_diff <= TOL);

  // Post-update horizontal and vertical counters; pixel mapping and the
  // timeout both look at the values that will be registered this edge.
  always_comb begin
    h_next = h_cnt;
    y_next = y_cnt;
    if (bus.dot_en) begin
      if (hs_fall) begin
        h_next = '0;
      end else if (h_cnt != 10'h3FF) begin
        h_next = h_cnt + 10'd1;
      end
      if (vb_fall) begin
        y_next = '0;
      end else if (hs_fall && (y_cnt != 9'h1FF)) begin
        y_next = y_cnt + 9'd1;
      end
    end
  end

  assign timeout = bus.dot_en & ~hs_fall & (h_next == TMO);

  // Lock state machine. A missing sync (timeout) overrides any line
  // evaluation; otherwise each hs_fall judges the line that just ended.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    miss_d  = miss_q;
    if (timeout) begin
      state_d = SEARCH;
      good_d  = '0;
      miss_d  = '0;
    end else if (hs_fall) begin
      case (state_q)
        SEARCH: begin
          state_d = MEASURE;
          good_d  = '0;
          miss_d  = '0;
        end
        MEASURE: begin
          if (!line_good) begin
            good_d = '0;
          end else if (good_q == GW'(LOCK_LINES - 1)) begin
            state_d = LOCKED;
            good_d  = '0;
            miss_d  = '0;
          end else begin
            good_d = good_q + GW'(1);
          end
        end
        LOCKED: begin
          if (line_good) begin
            miss_d = '0;
          end else if (miss_q == MW'(MISS_MAX - 1)) begin
            state_d = SEARCH;
            miss_d  = '0;
          end else begin
            miss_d = miss_q + MW'(1);
          end
        end
        default: begin
          state_d = SEARCH;
          good_d  = '0;
          miss_d  = '0;
        end
      endcase
    end
  end

  assign pix_ok = (state_d == LOCKED) & bus.dot_en & (h_next >= X_LO) & (h_next < X_HI)
                & (y_next < Y_HI) & ~bus.vbl;
  assign x_off  = 9'(h_next - X_LO);

  // All registers. Everything but frame_start is only touched on dot
  // cycles; px_x/px_y keep the last active coordinate when px_valid drops.
  always_ff @(posedge clk) begin
    if (mr) begin
      state_q       <= SEARCH;
      good_q        <= '0;
      miss_q        <= '0;
      prev_hs       <= 1'b1;
      prev_vbl      <= 1'b0;
      h_cnt         <= '0;
      y_cnt         <= '0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
      frame_start_q <= 1'b0;
      px_valid_q    <= 1'b0;
      px_data_q     <= 1'b0;
      px_x_q        <= '0;
      px_y_q        <= '0;
    end else begin
      state_q       <= state_d;
      good_q        <= good_d;
      miss_q        <= miss_d;
      frame_start_q <= 1'b0;
      if (bus.dot_en) begin
        prev_hs  <= bus.h_sync_n;
        prev_vbl <= bus.vbl;
        h_cnt    <= h_next;
        y_cnt    <= y_next;
        if (hs_fall) begin
          line_len_q <= len_new[9:0];
        end
        if (vb_fall) begin
          frame_lines_q <= y_cnt + {8'd0, hs_fall};
          frame_start_q <= 1'b1;
        end
        if (pix_ok) begin
          px_valid_q <= 1'b1;
          px_x_q     <= x_off;
          px_y_q     <= y_next[7:0];
          px_data_q  <= bus.video;
        end else begin
          px_valid_q <= 1'b0;
          px_data_q  <= 1'b0;
        end
      end
    end
  end

  assign bus.locked      = (state_q == LOCKED);
  assign bus.px_valid    = px_valid_q;
  assign bus.px_x        = px_x_q;
  assign bus.px_y        = px_y_q;
  assign bus.px_data     = px_data_q;
  assign bus.frame_start = frame_start_q;
  assign bus.line_len    = line_len_q;
  assign bus.frame_lines = frame_lines_q;

endmodule

// File: tb/tb_video_sync_decoder.sv
// tb_video_sync_decoder
// Drives directed Apple-1 style line/frame patterns into video_sync_decoder
// and checks every output on every cycle against a dot-level behavioural
// model, plus hand-computed expectations at key points. Frames are shortened
// (ACTIVE_H = 8, 12 lines per frame) so the whole run stays short.
module tb_video_sync_decoder;

  localparam int ACT_H     = 8;
  localparam int FRAME_LEN = 12;
  localparam int NOM       = 455;

  logic clk = 1'b0;
  logic mr  = 1'b1;

  video_sync_decoder_if vif ();

  video_sync_decoder #(.ACTIVE_H(ACT_H)) dut (
    .clk (clk),
    .mr  (mr),
    .bus (vif)
  );

  // Dot rate is half the clock rate; every dot is a dot_en cycle plus an idle cycle.
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit check_en = 1'b0;
  bit count_en = 1'b0;
  int pv_count = 0;
  int fs_count = 0;

  // Model state: plain integer counts of dots since the last sync fall and
  // lines since the last blanking fall, plus a lock phase.
  localparam int P_SEARCH = 0, P_MEASURE = 1, P_LOCKED = 2;
  int m_dots, m_lines, m_phase, m_good_run, m_bad_run;
  bit m_prev_hs, m_prev_vb;
  int exp_line_len, exp_frame_lines, exp_px_x, exp_px_y;
  bit exp_locked, exp_px_valid, exp_px_data, exp_frame_start;

  task automatic printSummary();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      if (fails >= 200) begin
        printSummary();
        $finish;
      end
    end
  endtask

  task automatic modelReset();
    m_dots = 0; m_lines = 0; m_phase = P_SEARCH; m_good_run = 0; m_bad_run = 0;
    m_prev_hs = 1'b1; m_prev_vb = 1'b0;
    exp_line_len = 0; exp_frame_lines = 0; exp_px_x = 0; exp_px_y = 0;
    exp_locked = 0; exp_px_valid = 0; exp_px_data = 0; exp_frame_start = 0;
  endtask

  // One dot of the reference receiver, straight from the timing rules.
  task automatic modelStep(input bit hs, input bit vb, input bit vd);
    bit fall, vfall, good;
    int len;
    fall  = m_prev_hs && !hs;
    vfall = m_prev_vb && !vb;
    good  = 1'b0;
    if (fall) begin
      len          = m_dots + 1;
      exp_line_len = len % 1024;
      good         = (len - NOM >= -2) && (len - NOM <= 2);
      m_dots       = 0;
    end else if (m_dots < 1023) begin
      m_dots++;
    end
    if (!fall && m_dots == 1000) begin
      m_phase = P_SEARCH; m_good_run = 0; m_bad_run = 0;
    end else if (fall) begin
      if (m_phase == P_SEARCH) begin
        m_phase = P_MEASURE; m_good_run = 0;
      end else if (m_phase == P_MEASURE) begin
        m_good_run = good ? m_good_run + 1 : 0;
        if (m_good_run == 4) begin
          m_phase = P_LOCKED; m_good_run = 0; m_bad_run = 0;
        end
      end else begin
        m_bad_run = good ? 0 : m_bad_run + 1;
        if (m_bad_run == 3) begin
          m_phase = P_SEARCH; m_bad_run = 0;
        end
      end
    end
    if (vfall) begin
      exp_frame_lines = (m_lines + int'(fall)) % 512;
      m_lines         = 0;
      exp_frame_start = 1'b1;
    end else begin
      if (fall && m_lines < 511) m_lines++;
      exp_frame_start = 1'b0;
    end
    exp_locked = (m_phase == P_LOCKED);
    if (exp_locked && m_dots >= 80 && m_dots < 360 && m_lines < ACT_H && !vb) begin
      exp_px_valid = 1'b1;
      exp_px_x     = m_dots - 80;
      exp_px_y     = m_lines % 256;
      exp_px_data  = vd;
    end else begin
      exp_px_valid = 1'b0;
      exp_px_data  = 1'b0;
    end
    m_prev_hs = hs;
    m_prev_vb = vb;
  endtask

  // One dot: a dot_en cycle carrying the inputs, then an idle cycle.
  task automatic applyStimulus(input bit hs, input bit vb, input bit vd);
    @(negedge clk);
    vif.dot_en   = 1'b1;
    vif.h_sync_n = hs;
    vif.vbl      = vb;
    vif.video    = vd;
    @(posedge clk);
    modelStep(hs, vb, vd);
    #1;
    if (count_en) begin
      pv_count += int'(vif.px_valid);
      fs_count += int'(vif.frame_start);
    end
    @(negedge clk);
    vif.dot_en = 1'b0;
    @(posedge clk);
    exp_frame_start = 1'b0;
  endtask

  // A line of len dots: sync low for the first 32 dots, video high only on
  // dot 'mark'. With probe set, the active-window edges are pinned literally.
  task automatic sendLine(input int len, input bit vb, input int mark, input bit probe);
    for (int d = 0; d < len; d++) begin
      applyStimulus(d >= 32, vb, d == mark);
      if (probe && (d == 80 || d == 359 || d == 360)) begin
        #1;
        if (d == 80) begin
          checkOutput("map_d80_valid", vif.px_valid, 1);
          checkOutput("map_d80_x", vif.px_x, 0);
          checkOutput("map_d80_y", vif.px_y, 0);
          checkOutput("map_d80_data", vif.px_data, 1);
        end else if (d == 359) begin
          checkOutput("map_d359_valid", vif.px_valid, 1);
          checkOutput("map_d359_x", vif.px_x, 279);
          checkOutput("map_d359_data", vif.px_data, 0);
        end else begin
          checkOutput("map_d360_valid", vif.px_valid, 0);
          checkOutput("map_d360_x_hold", vif.px_x, 279);
          checkOutput("map_d360_data", vif.px_data, 0);
        end
      end
    end
  endtask

  task automatic pulseReset();
    @(negedge clk);
    mr         = 1'b1;
    vif.dot_en = 1'b0;
    @(posedge clk);
    modelReset();
    @(negedge clk);
    mr = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_locked"}, vif.locked, 0);
    checkOutput({tag, "_px_valid"}, vif.px_valid, 0);
    checkOutput({tag, "_px_x"}, vif.px_x, 0);
    checkOutput({tag, "_px_y"}, vif.px_y, 0);
    checkOutput({tag, "_px_data"}, vif.px_data, 0);
    checkOutput({tag, "_frame_start"}, vif.frame_start, 0);
    checkOutput({tag, "_line_len"}, vif.line_len, 0);
    checkOutput({tag, "_frame_lines"}, vif.frame_lines, 0);
  endtask

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("cyc_locked", vif.locked, exp_locked);
      checkOutput("cyc_px_valid", vif.px_valid, exp_px_valid);
      checkOutput("cyc_px_x", vif.px_x, exp_px_x);
      checkOutput("cyc_px_y", vif.px_y, exp_px_y);
      checkOutput("cyc_px_data", vif.px_data, exp_px_data);
      checkOutput("cyc_frame_start", vif.frame_start, exp_frame_start);
      checkOutput("cyc_line_len", vif.line_len, exp_line_len);
      checkOutput("cyc_frame_lines", vif.frame_lines, exp_frame_lines);
    end
  end

  // Upper bound on the whole run.
  initial begin
    #1500000;
    tests++;
    fails++;
    $display("[TB] FAIL watchdog: run still active at t=%0t, required to end earlier", $time);
    printSummary();
    $finish;
  end

  // Directed scenario sequence.
  initial begin
    vif.dot_en   = 1'b0;
    vif.h_sync_n = 1'b1;
    vif.vbl      = 1'b0;
    vif.video    = 1'b0;
    modelReset();
    repeat (3) @(posedge clk);
    pulseReset();
    check_en = 1'b1;
    #1;
    checkAllZero("reset");

    // Nominal frames: 455-dot lines, blanking on lines 8..11.
    for (int f = 0; f < 3; f++) begin
      for (int l = 0; l < FRAME_LEN; l++) begin
        if (f == 1 && l == 0) count_en = 1'b1;
        sendLine(NOM, l >= ACT_H, (l == 0) ? 80 : -1, (f == 2) && (l == 0));
        if (f == 1 && l == FRAME_LEN - 1) count_en = 1'b0;
        #1;
        if (f == 0 && l == 3) checkOutput("no_lock_after_4_falls", vif.locked, 0);
        if (f == 0 && l == 4) checkOutput("lock_at_5th_fall", vif.locked, 1);
        if (f == 2 && l == 0) begin
          checkOutput("frame_lines_2nd_vfall", vif.frame_lines, 12);
          checkOutput("nominal_line_len", vif.line_len, 455);
        end
      end
    end
    checkOutput("px_valid_per_frame", pv_count, 280 * ACT_H);
    checkOutput("frame_start_pulses", fs_count, 1);

    // Tolerance: +/-2 keeps lock, single bad line kept, three bad lines drop.
    sendLine(457, 1'b0, -1, 1'b0);
    sendLine(453, 1'b0, -1, 1'b0);
    #1;
    checkOutput("tol_457_len", vif.line_len, 457);
    checkOutput("tol_457_locked", vif.locked, 1);
    sendLine(460, 1'b0, -1, 1'b0);
    sendLine(NOM, 1'b0, -1, 1'b0);
    #1;
    checkOutput("one_bad_len", vif.line_len, 460);
    checkOutput("one_bad_locked", vif.locked, 1);
    sendLine(460, 1'b0, -1, 1'b0);
    sendLine(460, 1'b0, -1, 1'b0);
    sendLine(460, 1'b0, -1, 1'b0);
    #1;
    checkOutput("two_bad_locked", vif.locked, 1);
    sendLine(NOM, 1'b0, -1, 1'b0);
    #1;
    checkOutput("three_bad_locked", vif.locked, 0);

    // Re-lock, then starve the sync until the timeout fires.
    repeat (4) sendLine(NOM, 1'b0, -1, 1'b0);
    sendLine(1000, 1'b0, -1, 1'b0);
    #1;
    checkOutput("pre_timeout_locked", vif.locked, 1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("timeout_locked", vif.locked, 0);
    for (int i = 0; i < 5; i++) begin
      sendLine(NOM, 1'b0, -1, 1'b0);
      #1;
      if (i == 0) checkOutput("len_after_timeout", vif.line_len, 1001);
      if (i == 3) checkOutput("relock_not_yet", vif.locked, 0);
      if (i == 4) checkOutput("relock_after_timeout", vif.locked, 1);
    end

    // Mid-line master reset.
    sendLine(300, 1'b0, -1, 1'b0);
    pulseReset();
    #1;
    checkAllZero("mid_reset");
    for (int i = 0; i < 5; i++) begin
      sendLine(NOM, 1'b0, -1, 1'b0);
      #1;
      if (i == 3) checkOutput("reset_relock_not_yet", vif.locked, 0);
      if (i == 4) checkOutput("reset_relock", vif.locked, 1);
    end

    repeat (4) @(posedge clk);
    check_en = 1'b0;
    printSummary();
    $finish;
  end

endmodule
